fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  hazard hold; IF/ID register and PC frozen while high.
REQ-005 branchTaken  input  1  redirect request from execute stage.
REQ-006 branchTarget  input  32  redirect PC; bits [1:0] ignored, forced to 00.
REQ-007 imem_req  output  1  instruction fetch request, level, asserted while waiting.
REQ-008 imem_addr  output  32  fetch address, equals PC.
REQ-009 imem_ready  input  1  imem_data valid this cycle for current imem_addr.
REQ-010 imem_data  input  32  fetched instruction word.
REQ-011 next_opCode  output  5  IF/ID opcode, instr[31:27]; feeds main control.
REQ-012 next_instr  output  32  IF/ID full instruction word.
REQ-013 next_pcPlus4  output  32  IF/ID address of fetched instruction + 4.
REQ-014 if_valid  output  1  IF/ID holds a real instruction (0 = bubble).

Function
REQ-015 States SHALL be FETCH (imem_req=1) and SKID (imem_req=0, one instruction buffered).
REQ-016 imem_addr SHALL equal PC in all states; PC SHALL advance by 4 modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-017 FETCH, imem_ready=1, stall=0, branchTaken=0: IF/ID <= {imem_data, PC+4, valid=1}; PC <= PC+4; stay FETCH.
REQ-018 FETCH, imem_ready=0, stall=0, branchTaken=0: IF/ID <= bubble (instr=0, opcode=0, pcPlus4=0, valid=0); PC unchanged.
REQ-019 FETCH, imem_ready=1, stall=1, branchTaken=0: skid <= {imem_data, PC+4}; PC <= PC+4; IF/ID held; go SKID.
REQ-020 FETCH, imem_ready=0, stall=1: IF/ID and PC held; stay FETCH.
REQ-021 SKID, stall=1, branchTaken=0: all state held; imem_req=0.
REQ-022 SKID, stall=0, branchTaken=0: IF/ID <= skid contents with valid=1; go FETCH (new request next cycle).
REQ-023 branchTaken=1 in any state SHALL win over stall and imem_ready: PC <= {branchTarget[31:2],2'b00}; IF/ID <= bubble; skid discarded; go FETCH.
REQ-024 An imem_ready coinciding with branchTaken SHALL be discarded, never reaching IF/ID.
REQ-025 Latency: instruction returned with imem_ready at edge N SHALL appear on next_opCode after edge N (visible cycle N+1) when unstalled.
REQ-026 IF/ID outputs SHALL be registered; no combinational path from imem_data or stall to next_* outputs.
REQ-027 next_opCode SHALL always equal next_instr[31:27].
REQ-028 At most one instruction SHALL be buffered; no fetch issued while in SKID, so no overflow.

Reset
REQ-029 reset=1 at a rising edge SHALL set PC=RESET_PC, state=FETCH, IF/ID=bubble, skid cleared, regardless of other inputs.
REQ-030 After reset: imem_req=1, imem_addr=RESET_PC, next_opCode=0, next_instr=0, next_pcPlus4=0, if_valid=0.
REQ-031 reset asserted mid-SKID or mid-stall SHALL discard buffered instruction; first post-reset fetch is RESET_PC.

Verification
REQ-032 Reset, then imem_ready=1 every cycle with data 0x0800_0000, 0x1000_0000: next_opCode 5'h01 then 5'h02, next_pcPlus4 4 then 8, if_valid=1.
REQ-033 imem_ready=0 for 3 cycles then 1: if_valid=0 for those cycles, imem_addr held at same PC, instruction appears one cycle after ready.
REQ-034 stall=1 with imem_ready=1 at PC=8: state SKID, imem_req=0, IF/ID unchanged; stall=0 -> IF/ID gets word from addr 8, pcPlus4=12.
REQ-035 branchTaken=1, branchTarget=0x0000_0103, stall=1, imem_ready=1 same cycle: PC=0x100, if_valid=0, returned word dropped.
REQ-036 PC=0xFFFF_FFFC, imem_ready=1: next_pcPlus4=0, next imem_addr=0.
REQ-037 reset asserted while in SKID: outputs match REQ-030 next cycle, imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, level-request imem handshake,
// one-entry skid buffer and registered IF/ID outputs.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [4:0]  next_opCode,
    output logic [31:0] next_instr,
    output logic [31:0] next_pcPlus4,
    output logic        if_valid
);

    typedef enum logic {FETCH, SKID} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] instr, instr_nxt;
    logic [31:0] pc4, pc4_nxt;
    logic        valid, valid_nxt;
    logic [31:0] skid_instr, skid_instr_nxt;
    logic [31:0] skid_pc4, skid_pc4_nxt;
    logic [31:0] pc_inc;

    assign pc_inc = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            instr      <= '0;
            pc4        <= '0;
            valid      <= 1'b0;
            skid_instr <= '0;
            skid_pc4   <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            instr      <= instr_nxt;
            pc4        <= pc4_nxt;
            valid      <= valid_nxt;
            skid_instr <= skid_instr_nxt;
            skid_pc4   <= skid_pc4_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        instr_nxt      = instr;
        pc4_nxt        = pc4;
        valid_nxt      = valid;
        skid_instr_nxt = skid_instr;
        skid_pc4_nxt   = skid_pc4;
        if (branchTaken) begin
            // Redirect outranks stall and drops any in-flight return.
            state_nxt      = FETCH;
            pc_nxt         = {branchTarget[31:2], 2'b00};
            instr_nxt      = '0;
            pc4_nxt        = '0;
            valid_nxt      = 1'b0;
            skid_instr_nxt = '0;
            skid_pc4_nxt   = '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (imem_ready) begin
                        pc_nxt = pc_inc;
                        if (stall) begin
                            skid_instr_nxt = imem_data;
                            skid_pc4_nxt   = pc_inc;
                            state_nxt      = SKID;
                        end else begin
                            instr_nxt = imem_data;
                            pc4_nxt   = pc_inc;
                            valid_nxt = 1'b1;
                        end
                    end else if (!stall) begin
                        instr_nxt = '0;
                        pc4_nxt   = '0;
                        valid_nxt = 1'b0;
                    end
                end
                SKID: begin
                    if (!stall) begin
                        instr_nxt      = skid_instr;
                        pc4_nxt        = skid_pc4;
                        valid_nxt      = 1'b1;
                        skid_instr_nxt = '0;
                        skid_pc4_nxt   = '0;
                        state_nxt      = FETCH;
                    end
                end
            endcase
        end
    end

    assign imem_req     = (state == FETCH);
    assign imem_addr    = pc;
    assign next_instr   = instr;
    assign next_opCode  = instr[31:27];
    assign next_pcPlus4 = pc4;
    assign if_valid     = valid;

endmodule
